// File: rtl/terminal_char_sender_pkg.sv
// Shared types and character constants for the video terminal character port.
package terminal_pkg;

  // Handshake FSM states of the transmit side
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK,
    RELEASE
  } state_e;

  // Carriage return goes through untouched; the terminal treats it as newline
  localparam logic [6:0] CHR_CR = 7'h0D;
  // Line feed is compared on the raw byte before translation
  localparam logic [7:0] CHR_LF = 8'h0A;

  // Lowercase ASCII range and the offset that folds it onto uppercase
  localparam logic [6:0] CHR_LC_FIRST = 7'h61;
  localparam logic [6:0] CHR_LC_LAST  = 7'h7A;
  localparam logic [6:0] CHR_CASE_OFS = 7'h20;

  // Byte-to-terminal-code translation: drop bit 7, optionally fold lowercase
  function automatic logic [6:0] to_term_code(input logic [7:0] b, input logic upcase);
    logic [6:0] c;
    c = b[6:0];
    if (upcase && (c >= CHR_LC_FIRST) && (c <= CHR_LC_LAST)) begin
      c = c - CHR_CASE_OFS;
    end
    return c;
  endfunction

endpackage

// File: rtl/terminal_char_sender_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// rd_data is valid whenever rd_valid is high; rd_ready pops the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push;
  logic             pop;

  // Ready and valid come straight from the registered count, never from wr_valid
  assign wr_ready = (count_q != FULL_C);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_ready & rd_valid;

  // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from before the edge.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; entries are only read once the count says they were written.
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/terminal_char_sender.sv
// Transmit end of the video terminal character port: buffers incoming bytes,
// translates them to terminal code and runs the rd/da vs rda_n 4-phase handshake.
module terminal_char_sender
  import terminal_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int UPCASE      = 1,
  parameter int DROP_LF     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:1]                  rd,
  output logic                        da,
  input  logic                        rda_n,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        timeout_err
);

  // One counter serves both SETUP and WAIT_ACK, so it must hold the larger of the
  // two limits; at least one bit so a disabled timeout still yields a legal vector.
  // SETUP_CYC is expected to be at least 1.
  localparam int CNT_W_TO  = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W_SU  = $clog2(SETUP_CYC + 1);
  localparam int CNT_W_RAW = (CNT_W_TO > CNT_W_SU) ? CNT_W_TO : CNT_W_SU;
  localparam int CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       rd_q, rd_d;
  logic             da_q, da_d;
  logic             timeout_err_q, timeout_err_d;
  logic             rda_meta_q, rda_meta_d;
  logic             rda_s_q, rda_s_d;

  logic             fifo_valid;
  logic             fifo_pop;
  logic [7:0]       fifo_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (in_data),
    .rd_valid (fifo_valid),
    .rd_ready (fifo_pop),
    .rd_data  (fifo_data),
    .count    (fifo_count)
  );

  assign rd          = rd_q;
  assign da          = da_q;
  assign timeout_err = timeout_err_q;
  assign busy        = fifo_valid | (state_q != IDLE);

  // Next-state logic for the handshake FSM and the rda_n synchronizer chain
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    da_d          = da_q;
    timeout_err_d = 1'b0;
    fifo_pop      = 1'b0;
    rda_meta_d    = rda_n;
    rda_s_d       = rda_meta_q;

    case (state_q)
      IDLE: begin
        // A low rda_s here is a stale or glitched ack: leave the FIFO alone until it clears
        if (fifo_valid && rda_s_q) begin
          fifo_pop = 1'b1;
          // A dropped line feed costs this one IDLE cycle and never touches rd
          if (!((DROP_LF != 0) && (fifo_data == CHR_LF))) begin
            rd_d    = to_term_code(fifo_data, UPCASE != 0);
            cnt_d   = '0;
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          da_d    = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_ACK: begin
        if (!rda_s_q) begin
          da_d    = 1'b0;
          state_d = RELEASE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_LAST)) begin
          da_d          = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RELEASE: begin
        if (rda_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM, output and synchronizer registers; reset drops da without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_q          <= '0;
      da_q          <= 1'b0;
      timeout_err_q <= 1'b0;
      rda_meta_q    <= 1'b1;
      rda_s_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      da_q          <= da_d;
      timeout_err_q <= timeout_err_d;
      rda_meta_q    <= rda_meta_d;
      rda_s_q       <= rda_s_d;
    end
  end

endmodule

// File: tb/tb_terminal_char_sender.sv
// Directed bench for terminal_char_sender: a behavioural terminal answers the
// handshake, and a second instance with a short timeout covers the abort path.
module tb_terminal_char_sender;

  localparam int SETUP = 4;
  localparam int CW    = 5;

  typedef enum int {T_AUTO, T_HI, T_LO} term_mode_e;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_valid_t;
  logic          in_ready, in_ready_t;
  logic [7:1]    rd, rd_t;
  logic          da, da_t;
  logic          rda_n = 1'b1;
  logic          rda_n_t;
  logic          busy, busy_t;
  logic [CW-1:0] fifo_count, fifo_count_t;
  logic          timeout_err, timeout_err_t;

  int            n_tests = 0;
  int            n_fail  = 0;

  term_mode_e    term_mode = T_HI;
  int            tph = 0;
  int            tcnt = 0;
  int            ack_lat = 0;
  logic          busy_at_release = 1'b0;
  logic [6:0]    rx_q [$];

  int            rd_stable = 0;
  int            setup_seen = 0;
  logic [7:1]    rd_prev = '0;
  logic          da_prev = 1'b0;
  int            te_cnt = 0;
  int            te_cnt_main = 0;

  assign rda_n_t = 1'b1;

  always #5 clk = ~clk;

  terminal_char_sender #(
    .FIFO_DEPTH (16), .SETUP_CYC (SETUP), .TIMEOUT_CYC (0), .UPCASE (1), .DROP_LF (1)
  ) u_dut (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
    .rd (rd), .da (da), .rda_n (rda_n), .busy (busy), .fifo_count (fifo_count),
    .timeout_err (timeout_err)
  );

  terminal_char_sender #(
    .FIFO_DEPTH (16), .SETUP_CYC (SETUP), .TIMEOUT_CYC (100), .UPCASE (1), .DROP_LF (1)
  ) u_dut_to (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid_t), .in_ready (in_ready_t),
    .rd (rd_t), .da (da_t), .rda_n (rda_n_t), .busy (busy_t), .fifo_count (fifo_count_t),
    .timeout_err (timeout_err_t)
  );

  // Terminal model: ack 3 clk after da rises, release 3 clk after da falls
  always @(negedge clk) begin
    if (term_mode == T_HI) begin
      rda_n = 1'b1;
      tph   = 0;
    end else if (term_mode == T_LO) begin
      rda_n = 1'b0;
      tph   = 0;
    end else begin
      case (tph)
        0: begin
          rda_n = 1'b1;
          if (da) begin
            tcnt = 0;
            tph  = 1;
          end
        end
        1: begin
          if (!da) tph = 0;
          else begin
            tcnt++;
            if (tcnt == 3) begin
              rda_n = 1'b0;
              rx_q.push_back(rd);
              ack_lat = 0;
              tph = 2;
            end
          end
        end
        2: begin
          ack_lat++;
          if (!da) begin
            tcnt = 0;
            tph  = 3;
          end
        end
        default: begin
          tcnt++;
          if (tcnt == 3) begin
            rda_n = 1'b1;
            busy_at_release = busy;
            tph = 0;
          end
        end
      endcase
    end
  end

  // Monitor: rd stability before each da rise, and timeout pulse counts
  always @(negedge clk) begin
    if (rd != rd_prev) rd_stable = 0;
    else rd_stable++;
    if (da && !da_prev) setup_seen = rd_stable;
    rd_prev = rd;
    da_prev = da;
    if (timeout_err_t) te_cnt++;
    if (timeout_err) te_cnt_main++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < rx_q.size()) return 32'(rx_q[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic push(input logic [7:0] b, input bit to_t);
    @(negedge clk);
    in_data = b;
    if (to_t) in_valid_t = 1'b1;
    else in_valid = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_valid_t = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || (tph != 0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic set_mode(input term_mode_e m);
    @(posedge clk);
    #1 term_mode = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    int hi;
    int te_base;
    logic da_seen;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_valid_t = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_rd",     32'(rd),          32'h0);
    check("rst_da",     32'(da),          32'h0);
    check("rst_ready",  32'(in_ready),    32'h1);
    check("rst_busy",   32'(busy),        32'h0);
    check("rst_count",  32'(fifo_count),  32'h0);
    check("rst_terr",   32'(timeout_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single character with a well-behaved terminal
    set_mode(T_AUTO);
    base = rx_q.size();
    push(8'h41, 1'b0);
    wait_idle("single_idle", 200);
    check("single_n",       32'(rx_q.size() - base), 32'd1);
    check("single_rd",      rx_at(base),             32'h41);
    check("single_setup",   32'(setup_seen >= SETUP), 32'd1);
    check("single_ack_lat", 32'(ack_lat <= 3),       32'd1);
    check("single_busy_rel", 32'(busy_at_release),   32'd1);

    // Lowercase folding, LF dropped, CR passed
    base = rx_q.size();
    push(8'h61, 1'b0);
    push(8'h0A, 1'b0);
    push(8'h0D, 1'b0);
    wait_idle("lf_idle", 400);
    check("lf_n",  32'(rx_q.size() - base), 32'd2);
    check("lf_c0", rx_at(base),             32'h41);
    check("lf_c1", rx_at(base + 1),         32'h0D);

    // FIFO full: first byte is held in WAIT_ACK, the next 16 fill the FIFO, the rest bounce
    set_mode(T_HI);
    base = rx_q.size();
    for (int i = 0; i < 20; i++) push(8'(8'h30 + i), 1'b0);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_ready", 32'(in_ready),   32'd0);
    check("full_da",    32'(da),         32'd1);
    set_mode(T_AUTO);
    wait_idle("full_idle", 2000);
    check("full_n", 32'(rx_q.size() - base), 32'd17);
    for (int i = 0; i < 17; i++) check($sformatf("full_c%0d", i), rx_at(base + i), 32'(8'h30 + i));
    check("full_no_terr", 32'(te_cnt_main), 32'd0);

    // Timeout on the second instance: rda_n stuck high
    te_base = te_cnt;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    n = 0;
    while (!da_t && (n < 50)) begin @(negedge clk); n++; end
    check("to_rise", 32'(da_t), 32'd1);
    check("to_rd0",  32'(rd_t), 32'h41);
    hi = 0;
    while (da_t && (hi < 500)) begin @(negedge clk); hi++; end
    check("to_da_width", 32'(hi), 32'd100);
    repeat (2) @(negedge clk);
    check("to_pulses", 32'(te_cnt - te_base), 32'd1);
    n = 0;
    while (!da_t && (n < 50)) begin @(negedge clk); n++; end
    check("to_next_da", 32'(da_t), 32'd1);
    check("to_next_rd", 32'(rd_t), 32'h42);

    // Reset in the middle of WAIT_ACK
    set_mode(T_HI);
    push(8'h52, 1'b0);
    push(8'h53, 1'b0);
    n = 0;
    while (!da && (n < 50)) begin @(negedge clk); n++; end
    check("mid_da_high", 32'(da), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_da",    32'(da),         32'd0);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_ready", 32'(in_ready),   32'd1);
    check("mid_busy",  32'(busy),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_mode(T_AUTO);
    base = rx_q.size();
    push(8'h55, 1'b0);
    wait_idle("mid_idle", 200);
    check("mid_n",  32'(rx_q.size() - base), 32'd1);
    check("mid_rx", rx_at(base),             32'h55);

    // Stale ack: rda_n already low when a byte arrives
    set_mode(T_LO);
    repeat (4) @(negedge clk);
    base = rx_q.size();
    push(8'h54, 1'b0);
    da_seen = 1'b0;
    repeat (10) begin @(negedge clk); da_seen = da_seen | da; end
    check("stale_no_da", 32'(da_seen),    32'd0);
    check("stale_count", 32'(fifo_count), 32'd1);
    set_mode(T_AUTO);
    da_seen = 1'b0;
    repeat (3) begin @(negedge clk); da_seen = da_seen | da; end
    check("stale_sync_gap", 32'(da_seen), 32'd0);
    wait_idle("stale_idle", 200);
    check("stale_n",  32'(rx_q.size() - base), 32'd1);
    check("stale_rx", rx_at(base),             32'h54);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
